// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch queue.
package fetch_pkg;

    localparam int DataSize = 32;
    localparam int MemSize  = 10;
    localparam int Depth    = 4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: IM request/response, head-of-queue handshake, redirect/halt control.
interface fetch_queue_if #(
    parameter int DataSize = fetch_pkg::DataSize,
    parameter int MemSize  = fetch_pkg::MemSize,
    parameter int Depth    = fetch_pkg::Depth
);
    localparam int CntW = $clog2(Depth) + 1;

    logic                im_enable_fetch;
    logic [MemSize-1:0]  im_address;
    logic [DataSize-1:0] im_data;
    logic [DataSize-1:0] ir;
    logic [MemSize-1:0]  ir_pc;
    logic                ir_valid;
    logic                ir_ready;
    logic                redirect;
    logic [MemSize-1:0]  redirect_pc;
    logic                halt;
    logic [CntW-1:0]     count;

    modport master (
        output im_enable_fetch, im_address, ir, ir_pc, ir_valid, count,
        input  im_data, ir_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  im_enable_fetch, im_address, ir, ir_pc, ir_valid, count,
        output im_data, ir_ready, redirect, redirect_pc, halt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Purpose: synchronous FIFO holding {instruction, pc} entries for the fetch stage.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop frees a slot; flush overrides push and pop.
module fetch_fifo #(
    parameter  int Width = fetch_pkg::DataSize + fetch_pkg::MemSize,
    parameter  int Depth = fetch_pkg::Depth,
    localparam int PtrW  = $clog2(Depth),
    localparam int CntW  = PtrW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [Width-1:0] i_push_dat,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [CntW-1:0]  o_count,
    output logic [Width-1:0] o_head_dat
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CntW'(Depth)) || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Purpose: owns the PC, issues IM word reads and queues returned instructions tagged with their PC.
// Latency: fetch issued in cycle N is valid at the head in cycle N+2; redirect refetches in R+1.
// Backpressure: issue stalls while queued + inflight entries fill the FIFO; ir_ready pops the head.
module fetch_queue #(
    parameter int DataSize = fetch_pkg::DataSize,
    parameter int MemSize  = fetch_pkg::MemSize,
    parameter int Depth    = fetch_pkg::Depth
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    import fetch_pkg::*;

    localparam int CntW = $clog2(Depth) + 1;
    localparam int EntW = DataSize + MemSize;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MemSize-1:0]  r_pc;
    logic [MemSize-1:0]  r_req_pc;
    logic                r_inflight;
    logic                r_kill;

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_valid;
    logic [CntW-1:0]     w_count;
    logic [CntW:0]       w_occ;
    logic [EntW-1:0]     w_head;

    // The outstanding IM read already owns a slot, so it is counted against the FIFO depth.
    assign w_occ   = {1'b0, w_count} + (CntW+1)'(r_inflight);
    assign w_issue = (r_state == RUN) && !bus.halt && !bus.redirect
                     && (w_occ < (CntW+1)'(Depth));
    assign w_valid = (w_count != '0);
    assign w_push  = r_inflight && !r_kill;
    assign w_pop   = w_valid && bus.ir_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     if (bus.halt)  w_state_nxt = HALTED;
            HALTED:  if (!bus.halt) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= '0;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= bus.redirect;
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
            if (bus.redirect) begin
                r_pc <= bus.redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + MemSize'(1);
            end
        end
    end

    fetch_fifo #(
        .Width (EntW),
        .Depth (Depth)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_push_dat ({bus.im_data, r_req_pc}),
        .i_pop      (w_pop),
        .i_flush    (bus.redirect),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    assign bus.im_enable_fetch   = w_issue;
    assign bus.im_address        = r_pc;
    assign {bus.ir, bus.ir_pc}   = w_head;
    assign bus.ir_valid          = w_valid;
    assign bus.count             = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: IM model holds word i = 0x1000+i, one-cycle registered read.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    int   cyc_n;

    logic [31:0] im_mem [1024];

    fetch_queue_if bus ();

    fetch_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.im_enable_fetch) begin
            bus.im_data <= im_mem[bus.im_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lands 1 time unit after the rising edge that starts cycle n (cycle 0 = first cycle out of reset).
    task automatic adv_to(input int n);
        while (cyc_n < n) begin
            @(posedge clk);
            #1;
            cyc_n++;
        end
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.ir_ready    = 1'b1;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc_n = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc_n = 0;
        for (int i = 0; i < 1024; i++) begin
            im_mem[i] = 32'h1000 + i;
        end
        reset           = 1'b0;
        bus.ir_ready    = 1'b1;
        bus.halt        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        #2;
        chk("rst_en",    32'(bus.im_enable_fetch), 32'd0);
        chk("rst_addr",  32'(bus.im_address),      32'd0);
        chk("rst_valid", 32'(bus.ir_valid),        32'd0);
        chk("rst_count", 32'(bus.count),           32'd0);
        chk("rst_ir",    bus.ir,                   32'd0);
        chk("rst_irpc",  32'(bus.ir_pc),           32'd0);

        // Streaming from reset release with the consumer always ready.
        do_reset();
        #2;
        chk("a_boot_en", 32'(bus.im_enable_fetch), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            adv_to(c);
            #2;
            chk($sformatf("a_en_c%0d", c),   32'(bus.im_enable_fetch), 32'd1);
            chk($sformatf("a_addr_c%0d", c), 32'(bus.im_address),      c - 1);
            if (c >= 3) begin
                chk($sformatf("a_valid_c%0d", c), 32'(bus.ir_valid), 32'd1);
                chk($sformatf("a_irpc_c%0d", c),  32'(bus.ir_pc),    c - 3);
                chk($sformatf("a_ir_c%0d", c),    bus.ir,            32'h1000 + c - 3);
            end else begin
                chk($sformatf("a_valid_c%0d", c), 32'(bus.ir_valid), 32'd0);
            end
        end

        // Consumer stalled for 10 cycles: queue fills with PCs 0-3, then drains in order.
        do_reset();
        bus.ir_ready = 1'b0;
        adv_to(4);
        #2;
        chk("b_en_c4",   32'(bus.im_enable_fetch), 32'd1);
        chk("b_addr_c4", 32'(bus.im_address),      32'd3);
        adv_to(5);
        #2;
        chk("b_en_full",  32'(bus.im_enable_fetch), 32'd0);
        chk("b_count_c5", 32'(bus.count),           32'd3);
        adv_to(9);
        #2;
        chk("b_count_full", 32'(bus.count),           32'd4);
        chk("b_valid_c9",   32'(bus.ir_valid),        32'd1);
        chk("b_irpc_c9",    32'(bus.ir_pc),           32'd0);
        chk("b_en_c9",      32'(bus.im_enable_fetch), 32'd0);
        adv_to(10);
        bus.ir_ready = 1'b1;
        #2;
        chk("b_irpc_c10", 32'(bus.ir_pc),           32'd0);
        chk("b_en_c10",   32'(bus.im_enable_fetch), 32'd0);
        for (int c = 11; c <= 16; c++) begin
            adv_to(c);
            #2;
            chk($sformatf("b_en_c%0d", c),   32'(bus.im_enable_fetch), 32'd1);
            chk($sformatf("b_addr_c%0d", c), 32'(bus.im_address),      c - 7);
            chk($sformatf("b_irpc_c%0d", c), 32'(bus.ir_pc),           c - 10);
            chk($sformatf("b_ir_c%0d", c),   bus.ir,                   32'h1000 + c - 10);
            if (c == 12) begin
                chk("b_count_c12", 32'(bus.count), 32'd2);
            end
        end

        // Redirect to 0x200 with three entries queued and PC 3 in flight.
        do_reset();
        bus.ir_ready = 1'b0;
        adv_to(5);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h200;
        #2;
        chk("c_count_pre", 32'(bus.count),           32'd3);
        chk("c_en_r",      32'(bus.im_enable_fetch), 32'd0);
        adv_to(6);
        bus.redirect = 1'b0;
        bus.ir_ready = 1'b1;
        #2;
        chk("c_valid_r1", 32'(bus.ir_valid),        32'd0);
        chk("c_count_r1", 32'(bus.count),           32'd0);
        chk("c_en_r1",    32'(bus.im_enable_fetch), 32'd1);
        chk("c_addr_r1",  32'(bus.im_address),      32'h200);
        adv_to(7);
        #2;
        chk("c_valid_r2", 32'(bus.ir_valid),   32'd0);
        chk("c_addr_r2",  32'(bus.im_address), 32'h201);
        adv_to(8);
        #2;
        chk("c_valid_r3", 32'(bus.ir_valid), 32'd1);
        chk("c_irpc_r3",  32'(bus.ir_pc),    32'h200);
        chk("c_ir_r3",    bus.ir,            32'h1200);
        adv_to(9);
        #2;
        chk("c_irpc_r4", 32'(bus.ir_pc), 32'h201);

        // Halt for five cycles mid-stream, then resume at the next sequential PC.
        do_reset();
        adv_to(5);
        bus.halt = 1'b1;
        #2;
        chk("d_en_h0",   32'(bus.im_enable_fetch), 32'd0);
        chk("d_irpc_h0", 32'(bus.ir_pc),           32'd2);
        adv_to(6);
        #2;
        chk("d_valid_h1", 32'(bus.ir_valid), 32'd1);
        chk("d_irpc_h1",  32'(bus.ir_pc),    32'd3);
        adv_to(7);
        #2;
        chk("d_valid_h2", 32'(bus.ir_valid), 32'd0);
        adv_to(9);
        #2;
        chk("d_en_h4", 32'(bus.im_enable_fetch), 32'd0);
        adv_to(10);
        bus.halt = 1'b0;
        #2;
        chk("d_en_rel", 32'(bus.im_enable_fetch), 32'd0);
        adv_to(11);
        #2;
        chk("d_en_res",   32'(bus.im_enable_fetch), 32'd1);
        chk("d_addr_res", 32'(bus.im_address),      32'd4);
        adv_to(13);
        #2;
        chk("d_valid_res", 32'(bus.ir_valid), 32'd1);
        chk("d_irpc_res",  32'(bus.ir_pc),    32'd4);
        chk("d_ir_res",    bus.ir,            32'h1004);

        // Back-to-back redirects starting in BOOT; the last one (0x3FF) wins and wraps.
        do_reset();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h123;
        #2;
        chk("e_en_boot", 32'(bus.im_enable_fetch), 32'd0);
        adv_to(1);
        bus.redirect_pc = 10'h3FF;
        #2;
        chk("e_en_r2", 32'(bus.im_enable_fetch), 32'd0);
        adv_to(2);
        bus.redirect = 1'b0;
        #2;
        chk("e_en_f0",   32'(bus.im_enable_fetch), 32'd1);
        chk("e_addr_f0", 32'(bus.im_address),      32'h3FF);
        adv_to(3);
        #2;
        chk("e_addr_wrap", 32'(bus.im_address), 32'h000);
        adv_to(4);
        #2;
        chk("e_valid_3ff", 32'(bus.ir_valid), 32'd1);
        chk("e_irpc_3ff",  32'(bus.ir_pc),    32'h3FF);
        chk("e_ir_3ff",    bus.ir,            32'h13FF);
        adv_to(5);
        #2;
        chk("e_irpc_000", 32'(bus.ir_pc), 32'h000);
        chk("e_ir_000",   bus.ir,         32'h1000);
        adv_to(6);
        #2;
        chk("e_irpc_001", 32'(bus.ir_pc), 32'h001);

        // Asynchronous reset while the queue is full, then restart from PC 0.
        do_reset();
        bus.ir_ready = 1'b0;
        adv_to(6);
        #2;
        chk("f_count_full", 32'(bus.count),      32'd4);
        chk("f_addr_pre",   32'(bus.im_address), 32'd4);
        reset = 1'b0;
        #1;
        chk("f_en_arst",    32'(bus.im_enable_fetch), 32'd0);
        chk("f_addr_arst",  32'(bus.im_address),      32'd0);
        chk("f_valid_arst", 32'(bus.ir_valid),        32'd0);
        chk("f_count_arst", 32'(bus.count),           32'd0);
        chk("f_ir_arst",    bus.ir,                   32'd0);
        chk("f_irpc_arst",  32'(bus.ir_pc),           32'd0);
        do_reset();
        #2;
        chk("f_en_boot", 32'(bus.im_enable_fetch), 32'd0);
        adv_to(1);
        #2;
        chk("f_en_c1",   32'(bus.im_enable_fetch), 32'd1);
        chk("f_addr_c1", 32'(bus.im_address),      32'd0);
        adv_to(3);
        #2;
        chk("f_valid_c3", 32'(bus.ir_valid), 32'd1);
        chk("f_irpc_c3",  32'(bus.ir_pc),    32'd0);
        chk("f_ir_c3",    bus.ir,            32'h1000);
        chk("f_count_c3", 32'(bus.count),    32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
